// File: rtl/ascii_scroll_display.sv
// Parametrised ASCII message display: a writable character buffer shown on
// NUM_DIGITS seven-segment digits, either as a static window or as a circular marquee.

module ASCII27Seg (
    input  logic [7:0] AsciiCode,
    output logic [6:0] HexSeg
);
    logic [7:0] up_char;

    // Active-low segments, bit order gfedcba; lower-case letters fold onto upper case
    always_comb begin
        up_char = AsciiCode;
        if ((AsciiCode >= 8'h61) && (AsciiCode <= 8'h7A)) begin
            up_char = AsciiCode & 8'hDF;
        end
        HexSeg = 7'h7F;
        case (up_char)
            "0":     HexSeg = 7'h40;
            "1":     HexSeg = 7'h79;
            "2":     HexSeg = 7'h24;
            "3":     HexSeg = 7'h30;
            "4":     HexSeg = 7'h19;
            "5":     HexSeg = 7'h12;
            "6":     HexSeg = 7'h02;
            "7":     HexSeg = 7'h78;
            "8":     HexSeg = 7'h00;
            "9":     HexSeg = 7'h10;
            "A":     HexSeg = 7'h08;
            "B":     HexSeg = 7'h03;
            "C":     HexSeg = 7'h46;
            "D":     HexSeg = 7'h21;
            "E":     HexSeg = 7'h06;
            "F":     HexSeg = 7'h0E;
            "G":     HexSeg = 7'h42;
            "H":     HexSeg = 7'h09;
            "I":     HexSeg = 7'h4F;
            "J":     HexSeg = 7'h61;
            "K":     HexSeg = 7'h0A;
            "L":     HexSeg = 7'h47;
            "M":     HexSeg = 7'h6A;
            "N":     HexSeg = 7'h2B;
            "O":     HexSeg = 7'h40;
            "P":     HexSeg = 7'h0C;
            "Q":     HexSeg = 7'h18;
            "R":     HexSeg = 7'h2F;
            "S":     HexSeg = 7'h12;
            "T":     HexSeg = 7'h07;
            "U":     HexSeg = 7'h41;
            "V":     HexSeg = 7'h63;
            "W":     HexSeg = 7'h55;
            "X":     HexSeg = 7'h36;
            "Y":     HexSeg = 7'h11;
            "Z":     HexSeg = 7'h24;
            "-":     HexSeg = 7'h3F;
            "_":     HexSeg = 7'h77;
            default: HexSeg = 7'h7F;
        endcase
    end
endmodule

module ascii_scroll_display #(
    parameter int NUM_DIGITS = 5,
    parameter int MSG_LEN    = 16,
    parameter int TICK_DIV   = 12500000,
    parameter int AW         = $clog2(MSG_LEN + 1)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    WrEn,
    input  logic [AW-1:0]           WrAddr,
    input  logic [7:0]              WrChar,
    input  logic                    LenLoad,
    input  logic [AW-1:0]           LenIn,
    input  logic                    Mode,
    input  logic                    Pause,
    output logic [7*NUM_DIGITS-1:0] HexSeg,
    output logic [AW-1:0]           Offset,
    output logic                    Wrapped
);
    localparam int IW = $clog2(MSG_LEN);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [AW-1:0] MSG_LEN_A = AW'(MSG_LEN);
    localparam logic [AW-1:0] DIGITS_A  = AW'(NUM_DIGITS);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [7:0]              msg_q [MSG_LEN];
    logic [7:0]              msg_d [MSG_LEN];
    logic [AW-1:0]           len_q, len_d;
    logic [AW-1:0]           offset_q, offset_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic                    wrapped_q, wrapped_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

    logic                    scroll_en;
    logic                    tick;
    logic [AW-1:0]           len_last;
    logic [AW-1:0]           sel_pos;
    logic [AW:0]             sel_idx;
    logic [7:0]              char_sel [NUM_DIGITS];
    logic [6:0]              seg_d    [NUM_DIGITS];

    assign scroll_en = Mode && (len_q > DIGITS_A);
    assign tick      = (presc_q == TICK_LAST);
    assign len_last  = len_q - AW'(1);

    always_comb begin
        msg_d = msg_q;
        if (WrEn && (WrAddr < MSG_LEN_A)) begin
            msg_d[WrAddr[IW-1:0]] = WrChar;
        end
    end

    // A length load outranks both the forced clear and any coincident step
    always_comb begin
        len_d     = len_q;
        offset_d  = offset_q;
        presc_d   = presc_q;
        wrapped_d = 1'b0;
        if (LenLoad) begin
            len_d    = (LenIn > MSG_LEN_A) ? MSG_LEN_A : LenIn;
            offset_d = '0;
            presc_d  = '0;
        end else if (!scroll_en) begin
            offset_d = '0;
            presc_d  = '0;
        end else if (!Pause) begin
            if (tick) begin
                presc_d = '0;
                if (offset_q == len_last) begin
                    offset_d  = '0;
                    wrapped_d = 1'b1;
                end else begin
                    offset_d = offset_q + AW'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Offset < Len and position < NUM_DIGITS < Len, so one subtraction wraps the index
    always_comb begin
        sel_pos = '0;
        sel_idx = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            sel_pos = AW'(NUM_DIGITS - 1 - k);
            sel_idx = {1'b0, offset_q} + {1'b0, sel_pos};
            if (sel_idx >= {1'b0, len_q}) begin
                sel_idx = sel_idx - {1'b0, len_q};
            end
            if (scroll_en) begin
                char_sel[k] = msg_q[sel_idx[IW-1:0]];
            end else if (sel_pos < len_q) begin
                char_sel[k] = msg_q[sel_pos[IW-1:0]];
            end else begin
                char_sel[k] = 8'h20;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        ASCII27Seg u_dec (
            .AsciiCode (char_sel[g]),
            .HexSeg    (seg_d[g])
        );
    end

    always_comb begin
        hex_d = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            hex_d[7*k +: 7] = seg_d[k];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            msg_q     <= '{default: 8'h20};
            len_q     <= '0;
            offset_q  <= '0;
            presc_q   <= '0;
            wrapped_q <= 1'b0;
            hex_q     <= '1;
        end else begin
            msg_q     <= msg_d;
            len_q     <= len_d;
            offset_q  <= offset_d;
            presc_q   <= presc_d;
            wrapped_q <= wrapped_d;
            hex_q     <= hex_d;
        end
    end

    assign HexSeg  = hex_q;
    assign Offset  = offset_q;
    assign Wrapped = wrapped_q;
endmodule

// File: tb/tb_ascii_scroll_display.sv
// Randomised bench for ascii_scroll_display: a message-level reference model is
// compared against the DUT on every falling edge, plus fixed directed scenarios.

module tb_ascii_scroll_display;
    localparam int ND = 5;
    localparam int ML = 16;
    localparam int TD = 4;
    localparam int AW = 5;

    localparam logic [34:0] ALL_BLANK = 35'h7FFFFFFFF;
    localparam logic [34:0] HELLO     = {7'h09, 7'h06, 7'h47, 7'h47, 7'h40};
    localparam logic [34:0] NPHEL     = {7'h2B, 7'h0C, 7'h09, 7'h06, 7'h47};
    localparam logic [34:0] LO_NP     = {7'h47, 7'h40, 7'h7F, 7'h2B, 7'h0C};

    logic          Clock = 1'b0;
    logic          Reset;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [7:0]    WrChar;
    logic          LenLoad;
    logic [AW-1:0] LenIn;
    logic          Mode;
    logic          Pause;
    logic [34:0]   HexSeg;
    logic [AW-1:0] Offset;
    logic          Wrapped;

    int errors = 0;
    int checks = 0;
    int wraps;
    bit check_en = 1'b0;

    // Reference model: message text, length, window start and step timer
    byte unsigned m_msg [ML];
    int           m_len;
    int           m_off;
    int           m_presc;
    bit           m_wrap;
    logic [34:0]  m_hex;

    byte unsigned alpha [16] = '{"H", "E", "L", "O", "N", "P", "A", "0",
                                 "1", "2", "3", "-", "e", "l", "o", " "};

    ascii_scroll_display #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .TICK_DIV   (TD)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrChar  (WrChar),
        .LenLoad (LenLoad),
        .LenIn   (LenIn),
        .Mode    (Mode),
        .Pause   (Pause),
        .HexSeg  (HexSeg),
        .Offset  (Offset),
        .Wrapped (Wrapped)
    );

    initial forever #5 Clock = ~Clock;

    function automatic logic [6:0] font(input byte unsigned c);
        case (c)
            "H":           return 7'h09;
            "E", "e":      return 7'h06;
            "L", "l":      return 7'h47;
            "O", "o", "0": return 7'h40;
            "N":           return 7'h2B;
            "P":           return 7'h0C;
            "A":           return 7'h08;
            "1":           return 7'h79;
            "2":           return 7'h24;
            "3":           return 7'h30;
            "-":           return 7'h3F;
            default:       return 7'h7F;
        endcase
    endfunction

    function automatic logic [34:0] model_hex(input bit mode);
        logic [34:0] r;
        bit scr;
        r   = '1;
        scr = mode && (m_len > ND);
        for (int k = 0; k < ND; k++) begin
            int i;
            byte unsigned c;
            i = ND - 1 - k;
            if (scr)            c = m_msg[(m_off + i) % m_len];
            else if (i < m_len) c = m_msg[i];
            else                c = " ";
            r[7*k +: 7] = font(c);
        end
        return r;
    endfunction

    task automatic model_step();
        bit scr;
        if (Reset) begin
            for (int i = 0; i < ML; i++) m_msg[i] = " ";
            m_len   = 0;
            m_off   = 0;
            m_presc = 0;
            m_wrap  = 1'b0;
            m_hex   = '1;
        end else begin
            scr    = Mode && (m_len > ND);
            m_hex  = model_hex(Mode);
            m_wrap = 1'b0;
            if (WrEn && (int'(WrAddr) < ML)) m_msg[WrAddr] = WrChar;
            if (LenLoad) begin
                m_len   = (int'(LenIn) > ML) ? ML : int'(LenIn);
                m_off   = 0;
                m_presc = 0;
            end else if (!scr) begin
                m_off   = 0;
                m_presc = 0;
            end else if (!Pause) begin
                m_presc++;
                if (m_presc == TD) begin
                    m_presc = 0;
                    m_off   = (m_off + 1) % m_len;
                    m_wrap  = (m_off == 0);
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(posedge Clock);
        model_step();
    end

    initial forever begin
        @(negedge Clock);
        if (check_en) begin
            check("hex", 64'(HexSeg), 64'(m_hex));
            check("offset", 64'(Offset), 64'(m_off));
            check("wrapped", 64'(Wrapped), 64'(m_wrap));
        end
    end

    task automatic cyc();
        @(negedge Clock);
    endtask

    task automatic wr(input int a, input byte unsigned c);
        WrEn   = 1'b1;
        WrAddr = AW'(a);
        WrChar = c;
        cyc();
        WrEn   = 1'b0;
    endtask

    task automatic load_len(input int n);
        LenLoad = 1'b1;
        LenIn   = AW'(n);
        cyc();
        LenLoad = 1'b0;
    endtask

    task automatic wait_offset(input int tgt, input int lim);
        int n;
        n = 0;
        while ((int'(Offset) != tgt) && (n < lim)) begin
            cyc();
            n++;
        end
        check("wait_offset", 64'(Offset), 64'(tgt));
    endtask

    initial begin
        byte unsigned hnp [8];
        hnp = '{"H", "E", "L", "L", "O", " ", "N", "P"};
        Reset = 1'b1; WrEn = 1'b0; WrAddr = '0; WrChar = 8'h00;
        LenLoad = 1'b0; LenIn = '0; Mode = 1'b0; Pause = 1'b0;
        cyc();
        cyc();
        check_en = 1'b1;
        check("reset_hex", 64'(HexSeg), 64'(ALL_BLANK));
        check("reset_offset", 64'(Offset), 64'd0);
        check("reset_wrapped", 64'(Wrapped), 64'd0);
        Reset = 1'b0;

        wr(0, "H"); wr(1, "e"); wr(2, "l"); wr(3, "l"); wr(4, "o");
        load_len(5);
        cyc();
        check("static_hello", 64'(HexSeg), 64'(HELLO));
        check("model_pin_hello", 64'(m_hex), 64'(HELLO));
        Mode = 1'b1;
        repeat (10) cyc();
        check("mode1_len5_static", 64'(HexSeg), 64'(HELLO));
        check("mode1_len5_offset", 64'(Offset), 64'd0);

        for (int i = 0; i < 8; i++) wr(i, hnp[i]);
        load_len(8);
        wraps = 0;
        repeat (40) begin
            cyc();
            if (Wrapped) wraps++;
        end
        check("wrap_count", 64'(wraps), 64'd1);

        wait_offset(6, 60);
        cyc();
        check("scroll_nphel", 64'(HexSeg), 64'(NPHEL));
        check("model_pin_nphel", 64'(m_hex), 64'(NPHEL));

        wait_offset(3, 40);
        Pause = 1'b1;
        repeat (20) cyc();
        check("pause_offset", 64'(Offset), 64'd3);
        check("pause_hex", 64'(HexSeg), 64'(LO_NP));
        Pause = 1'b0;
        repeat (3) cyc();
        check("unpause_hold", 64'(Offset), 64'd3);
        cyc();
        check("unpause_step", 64'(Offset), 64'd4);

        WrEn = 1'b1; WrAddr = AW'(16); WrChar = "A";
        cyc();
        WrEn = 1'b0;

        wait_offset(5, 20);
        Mode = 1'b0;
        cyc();
        check("mode0_offset", 64'(Offset), 64'd0);
        check("mode0_wrapped", 64'(Wrapped), 64'd0);
        cyc();
        check("mode0_static", 64'(HexSeg), 64'(HELLO));

        Mode = 1'b1;
        load_len(20);
        wait_offset(15, 100);
        repeat (3) cyc();

        Reset = 1'b1;
        cyc();
        check("midreset_hex", 64'(HexSeg), 64'(ALL_BLANK));
        check("midreset_offset", 64'(Offset), 64'd0);
        cyc();
        check("holdreset_hex", 64'(HexSeg), 64'(ALL_BLANK));
        check("holdreset_wrapped", 64'(Wrapped), 64'd0);
        Reset = 1'b0;

        repeat (1200) begin
            Reset   = ($urandom_range(0, 199) == 0);
            WrEn    = ($urandom_range(0, 2) == 0);
            WrAddr  = AW'($urandom_range(0, 18));
            WrChar  = alpha[$urandom_range(0, 15)];
            LenLoad = ($urandom_range(0, 24) == 0);
            LenIn   = AW'($urandom_range(0, 20));
            if ($urandom_range(0, 49) == 0) Mode = ~Mode;
            Pause   = ($urandom_range(0, 9) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
